// File: rtl/conv_frame_writer.sv
// -----------------------------------------------------------------------------
// conv_frame_writer
//
// Sink for the edge-detector output stream. Collects one output frame of
// (N-2) x (M-2) pixels after an arm pulse and packs four pixels per 32-bit
// word into a word-addressed frame-buffer write port. The final word is
// zero-padded in its unused upper lanes. frame_done pulses once the last word
// has been written.
//
// Handshake: valid/pixel_in is a push-only stream with no back-pressure.
// A pixel is taken on every rising edge where valid=1 and the FSM is in
// COLLECT. valid outside COLLECT drops the pixel and sets the sticky overrun
// flag. Throughput is one pixel per clock.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   arm          : one-cycle pulse, starts one frame (honoured only in IDLE)
//   pixel_in[7:0]: processed pixel
//   valid        : pixel qualifier
//   wr_en        : frame-buffer write strobe, one cycle per word
//   wr_addr      : frame-buffer word address
//   wr_data[31:0]: packed pixels, byte 0 = earliest pixel
//   col[15:0]    : output column of the next expected pixel
//   row[15:0]    : output row of the next expected pixel
//   busy         : frame collection in progress
//   frame_done   : one-cycle pulse after the last write
//   overrun      : sticky, valid seen while not collecting
//   o_dbg_state  : current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module conv_frame_writer #(
  parameter int N      = 480,
  parameter int M      = 857,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [7:0]        pixel_in,
  input  logic              valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       col,
  output logic [15:0]       row,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [1:0]        o_dbg_state
);

  localparam int P     = (N - 2) * (M - 2);
  localparam int CNT_W = $clog2(P + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(P - 1);
  localparam logic [15:0]      COL_LAST = 16'(N - 3);
  // A frame whose pixel count is not a multiple of four ends mid-word.
  localparam bit PARTIAL = (P % 4) != 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [23:0]        r_pack;
  logic [15:0]        r_col;
  logic [15:0]        r_row;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [31:0]        r_wr_data;
  logic               r_overrun;

  logic               w_start;
  logic               w_accept;
  logic               w_last;
  logic [1:0]         w_lane;
  logic [31:0]        w_word;

  assign w_start  = (r_state == S_IDLE) && arm;
  assign w_accept = (r_state == S_COLLECT) && valid;
  assign w_last   = (r_cnt == LAST_IDX);
  assign w_lane   = r_cnt[1:0];

  // Word formed by the incoming pixel plus the lanes already packed. Lanes
  // above the incoming one are zero, which is exactly the flush padding when
  // the frame ends mid-word.
  always_comb begin
    w_word = 32'h0;
    case (w_lane)
      2'd0:    w_word = {24'h0, pixel_in};
      2'd1:    w_word = {16'h0, pixel_in, r_pack[7:0]};
      2'd2:    w_word = {8'h0, pixel_in, r_pack[15:0]};
      default: w_word = {pixel_in, r_pack};
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm) w_next = S_COLLECT;
      end
      S_COLLECT: begin
        if (valid && w_last) w_next = PARTIAL ? S_FLUSH : S_DONE;
      end
      S_FLUSH: begin
        // The padded word was registered on the final pixel edge and is on
        // the write port during this cycle.
        w_next = S_DONE;
      end
      S_DONE: begin
        // For a full-word frame DONE is entered while the last write is still
        // on the port; hold one more cycle so frame_done follows that write.
        if (!r_wr_en) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pack    <= 24'h0;
      r_col     <= 16'h0;
      r_row     <= 16'h0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 32'h0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= 1'b0;

      if (r_wr_en) r_wr_addr <= r_wr_addr + 1'b1;

      if (w_start) begin
        r_cnt     <= '0;
        r_pack    <= 24'h0;
        r_col     <= 16'h0;
        r_row     <= 16'h0;
        r_wr_addr <= '0;
        r_overrun <= 1'b0;
      end else if (valid && (r_state != S_COLLECT)) begin
        r_overrun <= 1'b1;
      end

      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        case (w_lane)
          2'd0:    r_pack[7:0]   <= pixel_in;
          2'd1:    r_pack[15:8]  <= pixel_in;
          2'd2:    r_pack[23:16] <= pixel_in;
          default: ;
        endcase
        if (r_col == COL_LAST) begin
          r_col <= 16'h0;
          r_row <= r_row + 16'h1;
        end else begin
          r_col <= r_col + 16'h1;
        end
        if ((w_lane == 2'd3) || w_last) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_word;
        end
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign col         = r_col;
  assign row         = r_row;
  assign overrun     = r_overrun;
  assign busy        = (r_state == S_COLLECT) || (r_state == S_FLUSH) ||
                       ((r_state == S_DONE) && r_wr_en);
  assign frame_done  = (r_state == S_DONE) && !r_wr_en;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_frame_writer.sv
// -----------------------------------------------------------------------------
// Bench for conv_frame_writer. Two instances share clock and reset:
//   index 0 : N=6, M=5  -> 4 x 3 output, P=12 (whole words)
//   index 1 : N=7, M=4  -> 5 x 2 output, P=10 (ends mid-word)
// A monitor logs every write and frame_done pulse; each frame's log is
// compared with words built from the driven pixel list.
// -----------------------------------------------------------------------------
module tb_conv_frame_writer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]      arm;
  logic [1:0]      valid;
  logic [1:0][7:0] pixel;

  wire [1:0]       wr_en;
  wire [1:0]       busy;
  wire [1:0]       frame_done;
  wire [1:0]       overrun;
  wire [1:0][3:0]  wr_addr;
  wire [1:0][31:0] wr_data;
  wire [1:0][15:0] col;
  wire [1:0][15:0] row;
  wire [1:0][1:0]  dbg_state;

  conv_frame_writer #(.N(6), .M(5), .ADDR_W(4)) u_full (
    .clk(clk), .reset(rst_n), .arm(arm[0]), .pixel_in(pixel[0]), .valid(valid[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .col(col[0]), .row(row[0]), .busy(busy[0]), .frame_done(frame_done[0]),
    .overrun(overrun[0]), .o_dbg_state(dbg_state[0])
  );

  conv_frame_writer #(.N(7), .M(4), .ADDR_W(4)) u_part (
    .clk(clk), .reset(rst_n), .arm(arm[1]), .pixel_in(pixel[1]), .valid(valid[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .col(col[1]), .row(row[1]), .busy(busy[1]), .frame_done(frame_done[1]),
    .overrun(overrun[1]), .o_dbg_state(dbg_state[1])
  );

  // ---------------- monitor ----------------
  typedef struct {
    int          d;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t  obs_q[$];
  int   fd_cnt[2]  = '{0, 0};
  int   fd_cyc[2]  = '{0, 0};
  logic fd_busy[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en[d]) obs_q.push_back('{d: d, addr: int'(wr_addr[d]), data: wr_data[d], cyc: cyc});
      if (frame_done[d]) begin
        fd_cnt[d]  = fd_cnt[d] + 1;
        fd_cyc[d]  = cyc;
        fd_busy[d] = busy[d];
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] got_first;
  logic [31:0] got_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_d(input int d);
    int n = 0;
    foreach (obs_q[j]) if (obs_q[j].d == d) n++;
    return n;
  endfunction

  task automatic check_zero(input int d, input string tag);
    check({tag, "_data"}, wr_data[d], 64'h0);
    check({tag, "_ctrl"}, {wr_en[d], wr_addr[d], col[d], row[d], busy[d], frame_done[d], overrun[d]}, 64'h0);
  endtask

  // ---------------- driver + reference model ----------------
  // base >= 0 : pixels base, base+1, ...; base < 0 : random pixels.
  // gap 0: back-to-back, 1: one idle cycle before each pixel, 2: random 0..2.
  task automatic stream(input int d, input int base, input int gap, input bit rearm);
    int          p;
    int          w;
    int          nw;
    int          g;
    int          fd0;
    int          last;
    bit          seen;
    logic [31:0] word;
    logic [7:0]  pix[$];
    int          scyc[$];
    wr_t         mine[$];
    logic [31:0] exp_q[$];
    int          exp_cyc[$];

    p = (d == 0) ? 12 : 10;
    w = (d == 0) ? 4 : 5;

    @(negedge clk);
    obs_q.delete();
    fd0 = fd_cnt[d];
    arm[d] = 1'b1;
    @(negedge clk);
    arm[d] = 1'b0;
    check("busy_rise", busy[d], 64'd1);
    check("arm_clears_overrun", overrun[d], 64'd0);

    for (int i = 0; i < p; i++) begin
      g = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
      repeat (g) begin
        valid[d] = 1'b0;
        @(negedge clk);
      end
      check("col", col[d], 64'(i % w));
      check("row", row[d], 64'(i / w));
      pixel[d] = (base >= 0) ? 8'(base + i) : 8'($urandom_range(0, 255));
      pix.push_back(pixel[d]);
      valid[d] = 1'b1;
      arm[d]   = rearm && (i == 5);
      scyc.push_back(cyc + 1);
      @(negedge clk);
    end
    valid[d] = 1'b0;
    arm[d]   = 1'b0;
    check("row_end", row[d], (d == 0) ? 64'd3 : 64'd2);
    check("col_end", col[d], 64'd0);

    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (fd_cnt[d] != fd0) seen = 1'b1;
    end
    check("frame_done_seen", seen, 64'd1);

    // Expected words: pixels taken four at a time, earliest in byte 0,
    // missing tail bytes zero; each word is written the cycle its last
    // pixel is sampled.
    nw = (p + 3) / 4;
    for (int wi = 0; wi < nw; wi++) begin
      word = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * wi + b < p) word[8*b +: 8] = pix[4*wi + b];
      exp_q.push_back(word);
      last = (4 * wi + 3 < p) ? 4 * wi + 3 : p - 1;
      exp_cyc.push_back(scyc[last]);
    end

    foreach (obs_q[j]) if (obs_q[j].d == d) mine.push_back(obs_q[j]);
    check("write_count", 64'(mine.size()), 64'(nw));
    for (int wi = 0; wi < nw && wi < mine.size(); wi++) begin
      check("wr_data", mine[wi].data, exp_q[wi]);
      check("wr_addr", 64'(mine[wi].addr), 64'(wi));
      check("wr_cycle", 64'(mine[wi].cyc), 64'(exp_cyc[wi]));
    end
    got_first = (mine.size() > 0) ? mine[0].data : 32'hDEADBEEF;
    got_last  = (mine.size() > 0) ? mine[mine.size()-1].data : 32'hDEADBEEF;

    if (seen) begin
      check("frame_done_cycle", 64'(fd_cyc[d]), 64'(exp_cyc[nw-1] + 1));
      check("busy_low_at_done", fd_busy[d], 64'd0);
    end
    check("busy_after_frame", busy[d], 64'd0);
    check("overrun_in_frame", overrun[d], 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int n_before;

  initial begin
    rst_n = 1'b0;
    arm   = '0;
    valid = '0;
    pixel = '0;
    repeat (3) @(negedge clk);
    check_zero(0, "reset_full");
    check_zero(1, "reset_part");
    check("reset_state", dbg_state[0], 64'd0);
    rst_n = 1'b1;

    // Full-word frame 0x01..0x0C
    stream(0, 8'h01, 0, 1'b0);
    check("full_word0", got_first, 64'h04030201);
    check("full_word2", got_last, 64'h0C0B0A09);

    // Partial-word frame 0xA0..0xA9
    stream(1, 8'hA0, 0, 1'b0);
    check("part_word0", got_first, 64'hA3A2A1A0);
    check("part_flush", got_last, 64'h0000A9A8);

    // Gapped valid, same data as the full-word case
    stream(0, 8'h01, 1, 1'b0);
    check("gap_word0", got_first, 64'h04030201);
    check("gap_word2", got_last, 64'h0C0B0A09);

    // Unarmed valid in IDLE
    @(negedge clk);
    obs_q.delete();
    pixel[0] = 8'($urandom_range(0, 255));
    valid[0] = 1'b1;
    repeat (5) @(negedge clk);
    valid[0] = 1'b0;
    @(negedge clk);
    #1;
    check("idle_no_write", 64'(count_d(0)), 64'd0);
    check("idle_overrun", overrun[0], 64'd1);

    // Arm clears overrun (checked inside), then valid after frame_done
    stream(0, -1, 2, 1'b0);
    n_before = count_d(0);
    @(negedge clk);
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    @(negedge clk);
    #1;
    check("post_done_overrun", overrun[0], 64'd1);
    check("post_done_no_write", 64'(count_d(0)), 64'(n_before));

    // Reset mid-frame after 6 of 12 pixels
    @(negedge clk);
    arm[0] = 1'b1;
    @(negedge clk);
    arm[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pixel[0] = 8'($urandom_range(0, 255));
      valid[0] = 1'b1;
      @(negedge clk);
    end
    valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero(0, "mid_reset_async");
    @(negedge clk);
    check_zero(0, "mid_reset_held");
    rst_n = 1'b1;
    stream(0, -1, 0, 1'b0);

    // Random frames on both instances
    for (int r = 0; r < 4; r++) stream(r % 2, -1, 2, 1'b0);

    // Re-arm while collecting is ignored
    stream(0, -1, 0, 1'b1);
    stream(1, -1, 1, 1'b1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
